// File: rtl/boot_loader_ctrl.sv
// boot_loader_ctrl: parses a UART boot frame (A5, count, LE words) into imem writes, then releases the core.
// Optional trailing checksum byte and CSUM state are enabled by defining BOOT_CHECKSUM_EN.
module boot_loader_ctrl #(
    parameter int ADDR_W      = 10,
    parameter int TIMEOUT_CYC = 1_000_000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              io_i_boot,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    output logic              core_reset,
    output logic              busy,
    output logic [1:0]        err
);
    localparam logic [2:0] S_SYNC  = 3'd0;
    localparam logic [2:0] S_LEN0  = 3'd1;
    localparam logic [2:0] S_LEN1  = 3'd2;
    localparam logic [2:0] S_DATA  = 3'd3;
    localparam logic [2:0] S_WRITE = 3'd4;
    localparam logic [2:0] S_RUN   = 3'd6;
`ifdef BOOT_CHECKSUM_EN
    localparam logic [2:0] S_CSUM   = 3'd5;
    localparam logic [2:0] S_END    = S_CSUM;
    localparam logic [1:0] ERR_CSUM = 2'b11;
`else
    localparam logic [2:0] S_END    = S_RUN;
`endif
    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_TIMEOUT = 2'b01;
    localparam logic [1:0] ERR_FORMAT  = 2'b10;
    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [16:0]   MAX_WORDS  = 17'd1 << ADDR_W;

    logic [2:0]        state_r, state_s;
    logic [1:0]        byte_idx_r, byte_idx_s;
    logic [16:0]       word_cnt_r, word_cnt_s;
    logic [16:0]       len_r, len_s;
    logic [7:0]        len_lo_r, len_lo_s;
    logic [23:0]       asm_r, asm_s;
    logic [7:0]        hold_r, hold_s;
    logic              hold_vld_r, hold_vld_s;
    logic [TW-1:0]     timer_r, timer_s;
    logic              mem_req_r, mem_req_s;
    logic [ADDR_W-1:0] mem_addr_r, mem_addr_s;
    logic [31:0]       mem_wdata_r, mem_wdata_s;
    logic              core_reset_r, core_reset_s;
    logic              busy_r, busy_s;
    logic [1:0]        err_r, err_s;
`ifdef BOOT_CHECKSUM_EN
    logic [7:0]        sum_r, sum_s;
`endif

    logic        in_vld_s;
    logic [7:0]  in_byte_s;
    logic [16:0] n_s;
    logic [31:0] word_s;
    logic        last_word_s;
    logic        count_en_s;
    logic        timeout_s;

    // A byte parked during WRITE takes precedence over a fresh rx byte.
    assign in_vld_s    = hold_vld_r | rx_valid;
    assign in_byte_s   = hold_vld_r ? hold_r : rx_data;
    assign n_s         = {1'b0, rx_data, len_lo_r};
    assign word_s      = {in_byte_s, asm_r};
    assign last_word_s = (word_cnt_r + 17'd1) == len_r;
    assign count_en_s  = (state_r == S_LEN0) || (state_r == S_LEN1) || (state_r == S_DATA)
`ifdef BOOT_CHECKSUM_EN
                         || (state_r == S_CSUM)
`endif
                         ;

    // Next-state and next-output computation for the whole sequencer.
    always_comb begin
        state_s      = state_r;
        byte_idx_s   = byte_idx_r;
        word_cnt_s   = word_cnt_r;
        len_s        = len_r;
        len_lo_s     = len_lo_r;
        asm_s        = asm_r;
        hold_s       = hold_r;
        hold_vld_s   = hold_vld_r;
        timer_s      = timer_r;
        mem_addr_s   = mem_addr_r;
        mem_wdata_s  = mem_wdata_r;
        err_s        = err_r;
        timeout_s    = 1'b0;
`ifdef BOOT_CHECKSUM_EN
        sum_s        = sum_r;
`endif
        if (rx_valid) begin
            timer_s = '0;
        end else if (count_en_s) begin
            if (timer_r == TIMER_LAST) begin
                timeout_s = 1'b1;
            end else begin
                timer_s = timer_r + 1'b1;
            end
        end else begin
            timer_s = timer_r;
        end

        case (state_r)
            S_SYNC: begin
                if (!io_i_boot) begin
                    state_s = S_RUN;
                end else if (rx_valid && (rx_data == 8'hA5)) begin
                    state_s    = S_LEN0;
                    err_s      = ERR_NONE;
                    word_cnt_s = 17'd0;
                    hold_vld_s = 1'b0;
                    timer_s    = '0;
`ifdef BOOT_CHECKSUM_EN
                    sum_s      = 8'd0;
`endif
                end else begin
                    state_s = S_SYNC;
                end
            end
            S_LEN0: begin
                if (rx_valid) begin
                    len_lo_s = rx_data;
                    state_s  = S_LEN1;
                end else if (timeout_s) begin
                    state_s = S_SYNC;
                    err_s   = ERR_TIMEOUT;
                end else begin
                    state_s = S_LEN0;
                end
            end
            S_LEN1: begin
                if (rx_valid) begin
                    len_s      = n_s;
                    byte_idx_s = 2'd0;
                    word_cnt_s = 17'd0;
                    if (n_s > MAX_WORDS) begin
                        state_s = S_SYNC;
                        err_s   = ERR_FORMAT;
                    end else if (n_s == 17'd0) begin
                        state_s = S_END;
                    end else begin
                        state_s = S_DATA;
                    end
                end else if (timeout_s) begin
                    state_s = S_SYNC;
                    err_s   = ERR_TIMEOUT;
                end else begin
                    state_s = S_LEN1;
                end
            end
            S_DATA: begin
                if (in_vld_s) begin
                    hold_vld_s = hold_vld_r && rx_valid;
                    hold_s     = (hold_vld_r && rx_valid) ? rx_data : hold_r;
                    byte_idx_s = byte_idx_r + 2'd1;
`ifdef BOOT_CHECKSUM_EN
                    sum_s      = sum_r + in_byte_s;
`endif
                    case (byte_idx_r)
                        2'd0:    asm_s[7:0]   = in_byte_s;
                        2'd1:    asm_s[15:8]  = in_byte_s;
                        2'd2:    asm_s[23:16] = in_byte_s;
                        default: begin
                            state_s     = S_WRITE;
                            mem_addr_s  = word_cnt_r[ADDR_W-1:0];
                            mem_wdata_s = word_s;
                        end
                    endcase
                end else if (timeout_s) begin
                    state_s = S_SYNC;
                    err_s   = ERR_TIMEOUT;
                end else begin
                    state_s = S_DATA;
                end
            end
            S_WRITE: begin
                if (rx_valid && hold_vld_r) begin
                    state_s    = S_SYNC;
                    err_s      = ERR_FORMAT;
                    hold_vld_s = 1'b0;
                end else begin
                    if (rx_valid) begin
                        hold_s     = rx_data;
                        hold_vld_s = 1'b1;
                    end else begin
                        hold_vld_s = hold_vld_r;
                    end
                    if (mem_ack && mem_req_r) begin
                        word_cnt_s = word_cnt_r + 17'd1;
                        byte_idx_s = 2'd0;
                        state_s    = last_word_s ? S_END : S_DATA;
                    end else begin
                        state_s = S_WRITE;
                    end
                end
            end
`ifdef BOOT_CHECKSUM_EN
            S_CSUM: begin
                if (in_vld_s) begin
                    hold_vld_s = 1'b0;
                    if (in_byte_s == sum_r) begin
                        state_s = S_RUN;
                    end else begin
                        state_s = S_SYNC;
                        err_s   = ERR_CSUM;
                    end
                end else if (timeout_s) begin
                    state_s = S_SYNC;
                    err_s   = ERR_TIMEOUT;
                end else begin
                    state_s = S_CSUM;
                end
            end
`endif
            S_RUN:   state_s = S_RUN;
            default: state_s = S_SYNC;
        endcase

        // Request and core reset follow the state being entered so both stay registered.
        mem_req_s    = (state_s == S_WRITE);
        core_reset_s = (state_s != S_RUN);
        busy_s       = (state_s != S_SYNC) && (state_s != S_RUN);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r      <= S_SYNC;
            byte_idx_r   <= 2'd0;
            word_cnt_r   <= 17'd0;
            len_r        <= 17'd0;
            len_lo_r     <= 8'd0;
            asm_r        <= 24'd0;
            hold_r       <= 8'd0;
            hold_vld_r   <= 1'b0;
            timer_r      <= '0;
            mem_req_r    <= 1'b0;
            mem_addr_r   <= '0;
            mem_wdata_r  <= 32'd0;
            core_reset_r <= 1'b1;
            busy_r       <= 1'b0;
            err_r        <= ERR_NONE;
`ifdef BOOT_CHECKSUM_EN
            sum_r        <= 8'd0;
`endif
        end else begin
            state_r      <= state_s;
            byte_idx_r   <= byte_idx_s;
            word_cnt_r   <= word_cnt_s;
            len_r        <= len_s;
            len_lo_r     <= len_lo_s;
            asm_r        <= asm_s;
            hold_r       <= hold_s;
            hold_vld_r   <= hold_vld_s;
            timer_r      <= timer_s;
            mem_req_r    <= mem_req_s;
            mem_addr_r   <= mem_addr_s;
            mem_wdata_r  <= mem_wdata_s;
            core_reset_r <= core_reset_s;
            busy_r       <= busy_s;
            err_r        <= err_s;
`ifdef BOOT_CHECKSUM_EN
            sum_r        <= sum_s;
`endif
        end
    end

    assign mem_req    = mem_req_r;
    assign mem_addr   = mem_addr_r;
    assign mem_wdata  = mem_wdata_r;
    assign core_reset = core_reset_r;
    assign busy       = busy_r;
    assign err        = err_r;
endmodule

// File: doc/boot_loader_ctrl.md
# boot_loader_ctrl

UART boot-load sequencer between the SoC UART receiver and the instruction memory write port. It holds the RISC-V core in reset and parses a framed byte stream (sync, word count, little-endian 32-bit words) into instruction-memory writes starting at address 0. It then releases the core. When `io_i_boot` is low it releases the core immediately without loading.

## Interface
Parameters:
- `ADDR_W`, 10: instruction memory word-address width; capacity is 2^ADDR_W words.
- `TIMEOUT_CYC`, 1_000_000: idle cycles allowed between bytes inside a frame.

Ports:
- `clock` in 1: single clock for the whole block.
- `reset` in 1: synchronous, active-high.
- `io_i_boot` in 1: boot-load request; level-sampled in SYNC.
- `rx_valid` in 1: one-cycle pulse, `rx_data` valid.
- `rx_data` in 8: received UART byte.
- `mem_req` out 1: write request, held until acked.
- `mem_addr` out ADDR_W: word address.
- `mem_wdata` out 32: write data.
- `mem_ack` in 1: write accepted; may be asserted in the same cycle as `mem_req`.
- `core_reset` out 1: holds the core in reset while high.
- `busy` out 1: a frame is in progress (LEN0 through CSUM).
- `err` out 2: sticky error code. 00 none, 01 timeout, 10 format/overrun, 11 checksum.

## Operation
Reset values:
- `core_reset`=1
- `mem_req`=0, `mem_addr`=0, `mem_wdata`=0
- `busy`=0, `err`=00
- state=SYNC

States and transitions:
- SYNC:
  - If `io_i_boot`=0, go to RUN.
  - A byte 0xA5 goes to LEN0 and clears `err`.
  - Any other byte is ignored.
- LEN0 / LEN1: capture word count N (16-bit, LSB first).
  - If N > 2^ADDR_W, set err=10 and go to SYNC.
  - If N=0, go to CSUM (macro on) or RUN (macro off).
  - Otherwise go to DATA with byte index 0 and word index 0.
- DATA:
  - Shift bytes LSB-first into the 32-bit assembly register.
  - On the 4th byte, go to WRITE.
- WRITE:
  - `mem_req`=1, `mem_addr`=word index, `mem_wdata`=assembled word.
  - On `mem_ack`, increment the word index.
  - If this was the last word, go to CSUM (macro on) or RUN; otherwise go to DATA.
- CSUM: compare the byte with the 8-bit running sum of all data bytes.
  - Match goes to RUN.
  - Mismatch sets err=11 and goes to SYNC.
- RUN: `core_reset`=0. Terminal until `reset`.

Byte holding and overrun:
- A byte that arrives while in WRITE goes into a one-deep holding register.
- The held byte is consumed in the cycle after the ack, as the next DATA byte.
- A second byte arriving while the holding register is full sets err=10 and goes to SYNC.

Timeout:
- The counter clears on every `rx_valid` and on state entry to LEN0.
- The counter does not advance in WRITE.
- Reaching TIMEOUT_CYC in LEN0, LEN1, DATA or CSUM sets err=01 and goes to SYNC.

Error recovery:
- Any return to SYNC on error keeps `core_reset`=1 and `mem_req`=0.
- The word index resets to 0 on the next sync byte.
- `reset` in any state, including mid-WRITE, returns all outputs to their reset values next cycle. The memory contents are not touched.

## Timing
- 4th data byte in cycle t: `mem_req`=1 with valid addr/data in cycle t+1.
- `mem_ack` in cycle t: `mem_req`=0 in t+1; the request is never re-issued for the same word.
- `core_reset` falls:
  - 1 cycle after the final `mem_ack` (macro off);
  - 1 cycle after a matching checksum byte (macro on);
  - 1 cycle after SYNC sees `io_i_boot`=0.
- Outputs are registered, with no combinational path from `rx_*` to `mem_*`.
- `mem_ack` while `mem_req`=0 is ignored.

## Configuration
- `BOOT_CHECKSUM_EN` defined:
  - CSUM state and 8-bit sum accumulator are present.
  - The frame ends with the checksum byte.
  - err=11 is reachable.
- `BOOT_CHECKSUM_EN` undefined:
  - No CSUM state or accumulator.
  - The frame ends after the last word.
  - err never reports 11.

## Test plan
- `io_i_boot`=0 after reset release → `core_reset` falls 1 cycle later, no `mem_req`, err=00.
- Stream A5 02 00 | 13 00 00 00 | 93 00 10 00 | B6 (macro on) → writes addr0=0x00000013 and addr1=0x00100093, then `core_reset`=0, err=00.
- Same stream with checksum byte 0x00 → two writes occur, err=11, `core_reset` stays 1. A new valid frame then boots.
- A5 01 00 13 00, then silence ≥ TIMEOUT_CYC → err=01, state SYNC, `busy`=0, no write.
- A5 FF FF with ADDR_W=10 → err=10, no write.
- `mem_ack` held low while 2 further bytes arrive → err=10.
- `reset` asserted mid-WRITE with `mem_req`=1 → `mem_req`=0 and `core_reset`=1 next cycle, and a subsequent frame loads from addr 0.
